// File: rtl/sim_harness_pkg.sv
// -----------------------------------------------------------------------------
// sim_harness_pkg
// Shared types and constants for the simulation harness controller.
// The package holds the FSM state encoding, the default mailbox and console
// addresses, the tohost pass word and the fail code used for address errors.
// -----------------------------------------------------------------------------
package sim_harness_pkg;

    // Completion state. RUN is the only state with exits.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [31:0] DEF_TOHOST_ADDR  = 32'h0000_0FF0;
    localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h0000_0FF4;

    // tohost word that means "test passed"
    localparam int unsigned PASS_CODE = 32'd1;

    // Fail code reported for an out-of-window write; sliced to fail_code width
    localparam logic [63:0] ADDR_ERR_CODE = {64{1'b1}};

endpackage

// File: rtl/sim_harness_ctrl_if.sv
// -----------------------------------------------------------------------------
// sim_harness_ctrl_if
// Bundles the CPU data-memory write bus and the console valid/ready channel.
//   wr_en / wr_addr / wr_data : one CPU write per cycle (driven by master)
//   con_valid / con_data      : console byte offered to the bench (slave out)
//   con_ready                 : bench accepts the offered byte (master out)
// Modports: master = CPU/bench side, slave = harness controller.
// -----------------------------------------------------------------------------
interface sim_harness_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              con_valid;
    logic [7:0]        con_data;
    logic              con_ready;

    modport master (
        output wr_en, wr_addr, wr_data, con_ready,
        input  con_valid, con_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, con_ready,
        output con_valid, con_data
    );
endinterface

// File: rtl/harness_fifo.sv
// -----------------------------------------------------------------------------
// harness_fifo
// Synchronous FIFO with first-word latency of one cycle.
//   clk, reset : clock, asynchronous active-high reset
//   push       : write push_data (ignored when full unless a pop happens too)
//   pop        : read the head entry (ignored when empty)
//   pop_data   : head entry, valid while empty is low
//   full/empty : occupancy flags
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module harness_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign empty    = (count_r == '0);
    assign full     = (count_r == FULL_COUNT);
    assign pop_data = mem_r[rd_ptr_r];

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/sim_harness_ctrl.sv
// -----------------------------------------------------------------------------
// sim_harness_ctrl
// Test-harness controller snooping the CPU data-memory write bus.
// Detects test completion through a tohost pass/fail mailbox or a cycle
// watchdog, and buffers console bytes for the bench.
//   clk, reset     : clock, asynchronous active-high reset
//   bus (slave)    : wr_en/wr_addr/wr_data in, con_valid/con_data out,
//                    con_ready in
//   done           : test finished (pass, fail or timeout)
//   pass / timeout : outcome flags
//   fail_code      : tohost word >> 1 on failure, all ones on address error
//   cycle_count    : cycles spent in RUN (wraps silently)
//   fifo_overflow  : sticky, a console byte was dropped
//   err_addr       : first out-of-window write address
// Optional feature macro: SIM_HARNESS_ADDR_CHECK_EN enables the address
// window check; without it out-of-window writes are ignored and err_addr
// stays 0.
// -----------------------------------------------------------------------------
module sim_harness_ctrl
    import sim_harness_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(DEF_TOHOST_ADDR),
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR   = ADDR_W'(DEF_CONSOLE_ADDR),
    parameter int                MEM_BYTES      = 4096,
    parameter int                TIMEOUT_CYCLES = 325,
    parameter int                CNT_W          = 32,
    parameter int                FIFO_DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sim_harness_ctrl_if.slave    bus,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [DATA_W-2:0]    fail_code,
    output logic [CNT_W-1:0]     cycle_count,
    output logic                 fifo_overflow,
    output logic [ADDR_W-1:0]    err_addr
);
`ifdef SIM_HARNESS_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    state_t              state_r;
    logic                done_r;
    logic                pass_r;
    logic                timeout_r;
    logic [DATA_W-2:0]   fail_code_r;
    logic [CNT_W-1:0]    cycle_count_r;
    logic                overflow_r;
    logic [ADDR_W-1:0]   err_addr_r;

    logic                tohost_hit_s;
    logic                tohost_pass_s;
    logic                tohost_fail_s;
    logic                console_hit_s;
    logic                addr_err_s;
    logic                expire_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                con_pop_s;

    // Bus decode. A tohost word with bit 0 clear is not a report and is ignored.
    assign tohost_hit_s  = bus.wr_en && (bus.wr_addr == TOHOST_ADDR);
    assign tohost_pass_s = tohost_hit_s && (bus.wr_data == DATA_W'(PASS_CODE));
    assign tohost_fail_s = tohost_hit_s && bus.wr_data[0] && !tohost_pass_s;
    assign console_hit_s = bus.wr_en && (bus.wr_addr == CONSOLE_ADDR);

    // Out-of-window write; constant 0 when the address check is compiled out
    assign addr_err_s = ADDR_CHECK && bus.wr_en
                        && (bus.wr_addr >= ADDR_W'(MEM_BYTES))
                        && (bus.wr_addr != TOHOST_ADDR)
                        && (bus.wr_addr != CONSOLE_ADDR);

    // Expiry fires in the last cycle before the count reaches TIMEOUT_CYCLES
    assign expire_s = (TIMEOUT_CYCLES != 0)
                      && (cycle_count_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Completion FSM with registered status outputs; priority is
    // address error, then tohost, then watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_RUN;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            timeout_r     <= 1'b0;
            fail_code_r   <= '0;
            cycle_count_r <= '0;
            err_addr_r    <= '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    cycle_count_r <= cycle_count_r + CNT_W'(1);
                    if (addr_err_s) begin
                        state_r     <= ST_FAIL;
                        done_r      <= 1'b1;
                        fail_code_r <= ADDR_ERR_CODE[DATA_W-2:0];
                        err_addr_r  <= bus.wr_addr;
                    end else if (tohost_pass_s) begin
                        state_r <= ST_PASS;
                        done_r  <= 1'b1;
                        pass_r  <= 1'b1;
                    end else if (tohost_fail_s) begin
                        state_r     <= ST_FAIL;
                        done_r      <= 1'b1;
                        fail_code_r <= bus.wr_data[DATA_W-1:1];
                    end else if (expire_s) begin
                        state_r   <= ST_TIMEOUT;
                        done_r    <= 1'b1;
                        timeout_r <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    assign con_pop_s = !fifo_empty_s && bus.con_ready;

    // Sticky overflow: a push that found the FIFO full with no pop to make room
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (console_hit_s && fifo_full_s && !con_pop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    harness_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_con_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (console_hit_s),
        .push_data (bus.wr_data[7:0]),
        .pop       (bus.con_ready),
        .pop_data  (bus.con_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign bus.con_valid  = !fifo_empty_s;
    assign done           = done_r;
    assign pass           = pass_r;
    assign timeout        = timeout_r;
    assign fail_code      = fail_code_r;
    assign cycle_count    = cycle_count_r;
    assign fifo_overflow  = overflow_r;
    assign err_addr       = err_addr_r;
endmodule

// File: tb/tb_sim_harness_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sim_harness_ctrl
// Self-checking bench for sim_harness_ctrl. Inputs change on the falling
// edge, outputs are sampled on the falling edge. Console bytes are tracked
// in a scoreboard queue filled as writes are driven and emptied as the DUT
// hands bytes out.
// -----------------------------------------------------------------------------
module tb_sim_harness_ctrl;
    localparam logic [31:0] TOHOST  = 32'h0000_0FF0;
    localparam logic [31:0] CONSOLE = 32'h0000_0FF4;

    logic        clk;
    logic        reset;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;
    logic        fifo_overflow;
    logic [31:0] err_addr;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] sb[$];

    sim_harness_ctrl_if bus_if ();

    sim_harness_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_if),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .fail_code     (fail_code),
        .cycle_count   (cycle_count),
        .fifo_overflow (fifo_overflow),
        .err_addr      (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus_if.wr_en = 1'b0;
        bus_if.wr_addr = 32'h0;
        bus_if.wr_data = 32'h0;
        bus_if.con_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One-cycle write; console bytes enter the scoreboard while room remains
    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        bus_if.wr_en = 1'b1;
        bus_if.wr_addr = a;
        bus_if.wr_data = d;
        if (a == CONSOLE && !bus_if.con_ready && sb.size() < 8) sb.push_back(d[7:0]);
        tick();
        bus_if.wr_en = 1'b0;
        bus_if.wr_addr = 32'h0;
        bus_if.wr_data = 32'h0;
    endtask

    task automatic drain(input int budget);
        logic [7:0] exp_b;
        bus_if.con_ready = 1'b1;
        for (int i = 0; i < budget && sb.size() > 0; i++) begin
            if (bus_if.con_valid) begin
                exp_b = sb.pop_front();
                n_checks++;
                if (bus_if.con_data !== exp_b) $display("FAIL con_data: got %h want %h", bus_if.con_data, exp_b);
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (sb.size() != 0) $display("FAIL drain_budget: %0d bytes left, want 0", sb.size());
        else n_pass++;
        tick();
        n_checks++;
        if (bus_if.con_valid !== 1'b0) $display("FAIL drain_empty: con_valid %b want 0", bus_if.con_valid);
        else n_pass++;
        bus_if.con_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({done, pass, timeout, fifo_overflow, bus_if.con_valid} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {done, pass, timeout, fifo_overflow, bus_if.con_valid});
        else n_pass++;
        n_checks++;
        if (cycle_count !== 32'd0 || fail_code !== 31'd0 || err_addr !== 32'd0)
            $display("FAIL reset_values: cnt %0d code %h err %h want 0", cycle_count, fail_code, err_addr);
        else n_pass++;
    endtask

    task automatic test_pass();
        apply_reset();
        repeat (10) tick();
        write_word(TOHOST, 32'd1);
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || timeout !== 1'b0)
            $display("FAIL pass_flags: done %b pass %b timeout %b want 1 1 0", done, pass, timeout);
        else n_pass++;
        n_checks++;
        if (cycle_count !== 32'd11) $display("FAIL pass_count: got %0d want 11", cycle_count);
        else n_pass++;
        repeat (5) tick();
        write_word(TOHOST, 32'h7);
        n_checks++;
        if (pass !== 1'b1 || fail_code !== 31'd0 || cycle_count !== 32'd11)
            $display("FAIL pass_sticky: pass %b code %h cnt %0d want 1 0 11", pass, fail_code, cycle_count);
        else n_pass++;
        // console keeps working after done
        write_word(CONSOLE, 32'h5A);
        drain(10);
    endtask

    task automatic test_fail();
        apply_reset();
        write_word(TOHOST, 32'h4);
        n_checks++;
        if (done !== 1'b0) $display("FAIL even_word_ignored: done %b want 0", done);
        else n_pass++;
        write_word(TOHOST, 32'h7);
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 31'd3)
            $display("FAIL fail_code: done %b pass %b code %0d want 1 0 3", done, pass, fail_code);
        else n_pass++;
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < 400 && !done; i++) tick();
        n_checks++;
        if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0)
            $display("FAIL timeout_flags: done %b timeout %b pass %b want 1 1 0", done, timeout, pass);
        else n_pass++;
        n_checks++;
        if (cycle_count !== 32'd325) $display("FAIL timeout_count: got %0d want 325", cycle_count);
        else n_pass++;
        repeat (4) tick();
        n_checks++;
        if (cycle_count !== 32'd325) $display("FAIL timeout_frozen: got %0d want 325", cycle_count);
        else n_pass++;
        // tohost on the expiry cycle wins
        apply_reset();
        repeat (324) tick();
        n_checks++;
        if (done !== 1'b0 || cycle_count !== 32'd324) $display("FAIL race_pre: done %b cnt %0d want 0 324", done, cycle_count);
        else n_pass++;
        write_word(TOHOST, 32'd1);
        n_checks++;
        if (pass !== 1'b1 || timeout !== 1'b0 || cycle_count !== 32'd325)
            $display("FAIL race_tohost_wins: pass %b timeout %b cnt %0d want 1 0 325", pass, timeout, cycle_count);
        else n_pass++;
    endtask

    task automatic test_console();
        apply_reset();
        write_word(CONSOLE, 32'h48);
        n_checks++;
        if (bus_if.con_valid !== 1'b1) $display("FAIL con_latency: con_valid %b want 1", bus_if.con_valid);
        else n_pass++;
        write_word(CONSOLE, 32'h69);
        repeat (2) tick();
        n_checks++;
        if (bus_if.con_data !== 8'h48) $display("FAIL con_hold: got %h want 48", bus_if.con_data);
        else n_pass++;
        drain(10);
        n_checks++;
        if (fifo_overflow !== 1'b0) $display("FAIL con_no_overflow: got %b want 0", fifo_overflow);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] head;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            write_word(CONSOLE, 32'h30 + i);
            if (i == 7) begin
                n_checks++;
                if (fifo_overflow !== 1'b0) $display("FAIL ovf_at_full: got %b want 0", fifo_overflow);
                else n_pass++;
            end
        end
        n_checks++;
        if (fifo_overflow !== 1'b1) $display("FAIL ovf_ninth: got %b want 1", fifo_overflow);
        else n_pass++;
        drain(20);
        // full FIFO with push and pop together
        apply_reset();
        for (int i = 0; i < 8; i++) write_word(CONSOLE, 32'h40 + i);
        bus_if.con_ready = 1'b1;
        bus_if.wr_en = 1'b1;
        bus_if.wr_addr = CONSOLE;
        bus_if.wr_data = 32'h50;
        head = sb.pop_front();
        sb.push_back(8'h50);
        n_checks++;
        if (bus_if.con_data !== head) $display("FAIL full_pushpop_head: got %h want %h", bus_if.con_data, head);
        else n_pass++;
        tick();
        bus_if.wr_en = 1'b0;
        bus_if.con_ready = 1'b0;
        n_checks++;
        if (fifo_overflow !== 1'b0) $display("FAIL full_pushpop_ovf: got %b want 0", fifo_overflow);
        else n_pass++;
        drain(20);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        write_word(CONSOLE, 32'h55);
        repeat (49) tick();
        n_checks++;
        if (cycle_count !== 32'd50 || bus_if.con_valid !== 1'b1)
            $display("FAIL mid_pre: cnt %0d valid %b want 50 1", cycle_count, bus_if.con_valid);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (cycle_count !== 32'd0 || bus_if.con_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL mid_async: cnt %0d valid %b done %b want 0 0 0", cycle_count, bus_if.con_valid, done);
        else n_pass++;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (cycle_count !== 32'd3) $display("FAIL mid_restart: got %0d want 3", cycle_count);
        else n_pass++;
    endtask

    task automatic test_addr_check();
        logic [30:0] all_ones;
        all_ones = '1;
        apply_reset();
        write_word(32'h2000, 32'h1234);
`ifdef SIM_HARNESS_ADDR_CHECK_EN
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b0 || fail_code !== all_ones)
            $display("FAIL addr_err_fail: done %b pass %b code %h want 1 0 %h", done, pass, fail_code, all_ones);
        else n_pass++;
        write_word(32'h3000, 32'h0);
        n_checks++;
        if (err_addr !== 32'h2000) $display("FAIL addr_err_latch: got %h want 2000", err_addr);
        else n_pass++;
`else
        n_checks++;
        if (done !== 1'b0 || err_addr !== 32'h0 || fail_code === all_ones)
            $display("FAIL addr_ignored: done %b err %h code %h want 0 0 0", done, err_addr, fail_code);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_console();
        test_overflow();
        test_reset_mid();
        test_addr_check();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
